// File: rtl/axilite_m_ctrl.sv
// ---------------------------------------------------------------------------
// axilite_m_ctrl
//
// Single-outstanding AXI-Lite master sequencer. Turns one command on the
// simple cmd_* port into a correctly ordered AW/W/B (write) or AR/R (read)
// exchange with an AXI-Lite slave, and reports completion on rsp_*.
//
// Ports:
//   s_axi_aclk, s_axi_aresetn   clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only when idle)
//   cmd_we, cmd_addr, cmd_wdata command contents (wdata unused for reads)
//   rsp_valid                   one-cycle completion pulse
//   rsp_rdata, rsp_resp         read data (0 for writes) and bresp/rresp;
//                               held until the next completion
//   m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*
//                               AXI-Lite master channels
//
// Compile-time option:
//   AXIL_TIMEOUT_EN  when defined, every wait state (WR_AW_W, WR_B, RD_AR,
//                    RD_R) is bounded by TIMEOUT_CYC cycles. On expiry the
//                    exchange is abandoned: all channel valids/readies drop
//                    and the command completes with rsp_resp = 2'b10 and
//                    rsp_rdata = 0. This is a deliberate protocol abort
//                    intended for debug only.
//
// Every output is driven directly from a flop.
// ---------------------------------------------------------------------------
module axilite_m_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  // command / response port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  // write address channel
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  // write data channel
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  output logic [DATA_W-1:0] m_axi_wdata,
  // write response channel
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  input  logic [1:0]        m_axi_bresp,
  // read address channel
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  // read data channel
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_AW_W = 3'd1,
    S_WR_B    = 3'd2,
    S_RD_AR   = 3'd3,
    S_RD_R    = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e              state_q;
  logic                cmd_ready_q;
  logic                awvalid_q;
  logic [ADDR_W-1:0]   awaddr_q;
  logic                wvalid_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                bready_q;
  logic                arvalid_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic                rready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [1:0]          rsp_resp_q;

  // Handshake qualifiers. A channel is "finished" for this edge when it was
  // already done earlier (valid low) or its handshake completes now, which
  // lets AW and W complete in either order or together.
  logic cmd_hs;
  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;
  logic b_hs;
  logic ar_hs;
  logic r_hs;

  assign cmd_hs = cmd_ready_q & cmd_valid;
  assign aw_hs  = awvalid_q & m_axi_awready;
  assign w_hs   = wvalid_q & m_axi_wready;
  assign aw_fin = ~awvalid_q | m_axi_awready;
  assign w_fin  = ~wvalid_q | m_axi_wready;
  // bready/rready are high only in their wait states, so a stray
  // bvalid/rvalid elsewhere never qualifies as a handshake.
  assign b_hs   = bready_q & m_axi_bvalid;
  assign ar_hs  = arvalid_q & m_axi_arready;
  assign r_hs   = rready_q & m_axi_rvalid;

`ifdef AXIL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             in_wait;
  logic             leave_wait;
  logic             tmo;

  assign in_wait    = (state_q == S_WR_AW_W) || (state_q == S_WR_B) ||
                      (state_q == S_RD_AR)   || (state_q == S_RD_R);
  assign leave_wait = ((state_q == S_WR_AW_W) && aw_fin && w_fin) ||
                      ((state_q == S_WR_B)    && b_hs)            ||
                      ((state_q == S_RD_AR)   && ar_hs)           ||
                      ((state_q == S_RD_R)    && r_hs);
  // wait_cnt_q counts completed cycles in the current wait state; the abort
  // edge is the TIMEOUT_CYC-th edge after entry. A handshake landing on
  // that same edge wins over the abort.
  assign tmo        = in_wait && !leave_wait &&
                      (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      wvalid_q    <= 1'b0;
      wdata_q     <= '0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
`ifdef AXIL_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      // rsp_valid is a single-cycle pulse raised on entry to DONE.
      rsp_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (cmd_hs) begin
            cmd_ready_q <= 1'b0;
            if (cmd_we) begin
              awaddr_q  <= cmd_addr;
              wdata_q   <= cmd_wdata;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WR_AW_W;
            end else begin
              araddr_q  <= cmd_addr;
              arvalid_q <= 1'b1;
              state_q   <= S_RD_AR;
            end
          end else begin
            // Also covers the first edge after reset release.
            cmd_ready_q <= 1'b1;
          end
        end

        S_WR_AW_W: begin
          // AW and W retire independently; address/data registers are not
          // touched here, so they stay stable while their valid is high.
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_B;
          end
        end

        S_WR_B: begin
          if (b_hs) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= m_axi_bresp;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_RD_AR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_R;
          end
        end

        S_RD_R: begin
          if (r_hs) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= m_axi_rdata;
            rsp_resp_q  <= m_axi_rresp;
            rsp_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_DONE: begin
          // cmd_ready returns together with IDLE, so consecutive commands
          // are always separated by this DONE cycle.
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase

`ifdef AXIL_TIMEOUT_EN
      // Abort overrides whatever the wait state scheduled above.
      if (tmo) begin
        awvalid_q   <= 1'b0;
        wvalid_q    <= 1'b0;
        bready_q    <= 1'b0;
        arvalid_q   <= 1'b0;
        rready_q    <= 1'b0;
        rsp_resp_q  <= 2'b10;
        rsp_rdata_q <= '0;
        rsp_valid_q <= 1'b1;
        state_q     <= S_DONE;
      end

      // Cleared on every state change, so each wait state starts at zero.
      if (in_wait && !leave_wait) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end
`endif
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: doc/axilite_m_ctrl.md
Name:
axilite_m_ctrl

Overview:
- Single-outstanding AXI-Lite master sequencer that drives the team's AXI-Lite memory slave (128 x 32-bit words, bresp/rresp 2'b11 on out-of-range).
- Converts a simple command/response port (one read or write per command) into correctly ordered AW/W/B or AR/R handshakes.
- Sits between the bench or firmware-side logic and the slave. Used for bring-up, register-init sequencing and the slave's system test.

Parameters:
- ADDR_W, 32, width of cmd_addr, m_axi_awaddr and m_axi_araddr.
- DATA_W, 32, width of the write/read data paths.
- TIMEOUT_CYC, 64, wait-state cycle limit. Used only with AXIL_TIMEOUT_EN.

Ports:
- s_axi_aclk  in  1  clock; all logic on the rising edge.
- s_axi_aresetn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller can accept a command (IDLE only).
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data (ignored for reads).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  captured bresp/rresp, or 2'b10 on timeout.
- m_axi_awvalid / m_axi_awready / m_axi_awaddr  out/in/out  1/1/ADDR_W  write address channel.
- m_axi_wvalid / m_axi_wready / m_axi_wdata  out/in/out  1/1/DATA_W  write data channel.
- m_axi_bvalid / m_axi_bready / m_axi_bresp  in/out/in  1/1/2  write response channel.
- m_axi_arvalid / m_axi_arready / m_axi_araddr  out/in/out  1/1/ADDR_W  read address channel.
- m_axi_rvalid / m_axi_rready / m_axi_rdata / m_axi_rresp  in/out/in/in  1/1/DATA_W/2  read data channel.

Behaviour:
- Reset:
  - Asynchronous assertion, synchronous-release style: state is IDLE immediately.
  - All valids, readies, rsp_* and addr/data outputs are 0.
  - cmd_ready rises on the first edge after release.
  - Reset mid-transaction abandons the transaction with no rsp_valid.
- All outputs are registered.
- A handshake completes on the edge where valid and ready are both 1.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, capture we/addr/wdata and set cmd_ready=0. Go to WR_AW_W if we, else RD_AR.
  - WR_AW_W: awvalid and wvalid rise together on the next edge. Each is held until its own handshake, then dropped on the following edge, independently. The slave accepts AW before W; the controller must tolerate AW before W, W before AW, or both in the same cycle. Address and data stay stable while the corresponding valid is high. When both are done, go to WR_B.
  - WR_B: bready=1. On bvalid, capture bresp, drop bready, go to DONE.
  - RD_AR: arvalid=1 until arready handshake, then RD_R.
  - RD_R: rready=1. On rvalid, capture rdata and rresp, drop rready, go to DONE.
  - DONE: rsp_valid=1 for exactly one cycle with the captured rsp_rdata/rsp_resp, then IDLE. cmd_ready returns on the next cycle, so back-to-back commands are separated by at least 1 idle cycle.
- Only one transaction is outstanding. Commands are never queued. cmd_valid is ignored outside IDLE.
- rsp_rdata and rsp_resp hold their values until the next DONE.
- An unused bvalid/rvalid arriving outside its wait state is ignored.

Optional Feature:
- Macro: AXIL_TIMEOUT_EN.
- Defined:
  - A wait counter is cleared on entry to each of WR_AW_W, WR_B, RD_AR and RD_R, and increments every cycle in that state.
  - When it reaches TIMEOUT_CYC, all m_axi valids/readies drop, rsp_resp=2'b10, rsp_rdata=0, and the state goes to DONE.
  - This is an intentional protocol abort for debug.
- Undefined: no counter; wait states wait forever.

Test Plan:
- Write cmd addr 5, data 0xDEADBEEF against the slave -> one AW and one W handshake, bready handshake, rsp_valid pulse with rsp_resp=2'b00, rsp_rdata=0.
- Read cmd addr 5 after the write -> one AR handshake, rsp_rdata=0xDEADBEEF, rsp_resp=2'b00, exactly one rsp_valid pulse.
- Write addr 200, then read addr 200 -> write rsp_resp=2'b11; read rsp_resp=2'b11, rsp_rdata=0.
- Stub slave asserting wready 3 cycles before awready, then bvalid delayed 5 cycles -> each valid drops on the edge after its handshake, exactly one rsp_valid, no duplicate handshakes.
- AXIL_TIMEOUT_EN, TIMEOUT_CYC=16, awready tied 0 -> rsp_valid 16 cycles after WR_AW_W entry, rsp_resp=2'b10, awvalid=wvalid=0 afterwards.
- Assert s_axi_aresetn low during WR_B -> bready and all outputs 0 immediately, no rsp_valid; cmd_ready=1 one edge after release.
